// File: rtl/lsu_align_if.sv
// +----------------------------------------------------------------------+
// | lsu_align_if : request/response and data-cache bus of lsu_align      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface lsu_align_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [1:0]          req_size;
   logic                req_unsigned;
   logic [ADDR_W-1:0]   req_addr;
   logic [XLEN-1:0]     req_wdata;
   logic                resp_valid;
   logic [XLEN-1:0]     resp_rdata;
   logic                resp_err;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_re;
   logic [XLEN/8-1:0]   mem_we;
   logic [XLEN-1:0]     mem_din;
   logic [XLEN-1:0]     mem_dout;
   logic                mem_stall;

   // master: the alignment unit itself; slave: pipeline + cache side
   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_dout, mem_stall,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_re, mem_we, mem_din
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_dout, mem_stall,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_re, mem_we, mem_din
   );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align : load/store alignment, word-crossing split, load extend   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  wire logic   clk,
   input  wire logic   reset,
   lsu_align_if.master bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SPLIT = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                split_q, we_q, uns_q, err_q;
   logic [1:0]          size_q;
   logic [OFF_W-1:0]    off_q;
   logic [ADDR_W-1:0]   addr1_q;
   logic [NB-1:0]       mask1_q;
   logic [XLEN-1:0]     data1_q;
   logic [XLEN-1:0]     lo_q;

   logic [OFF_W-1:0]    w_off;
   logic [3:0]          w_bytes;
   logic                w_illegal, w_split, w_ready, w_accept;
   logic [2*NB-1:0]     w_mask2;
   logic [2*XLEN-1:0]   w_data2;
   logic [ADDR_W-1:0]   w_addr0;

   assign w_off     = bus.req_addr[OFF_W-1:0];
   assign w_bytes   = 4'd1 << bus.req_size;
   assign w_illegal = (XLEN == 32) && (bus.req_size == 2'd3);
   assign w_split   = !w_illegal && ((int'(w_off) + int'(w_bytes)) > NB);
   assign w_mask2   = ~({2*NB{1'b1}} << w_bytes) << w_off;
   assign w_data2   = {{XLEN{1'b0}}, bus.req_wdata} << {w_off, 3'b000};
   assign w_addr0   = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   // Ready in WAIT only after a non-split access: gives 1/cycle aligned throughput
   assign w_ready   = (state_q == S_IDLE) || ((state_q == S_WAIT) && !split_q);
   assign w_accept  = bus.req_valid && w_ready && !bus.mem_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         split_q <= 1'b0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= '0;
         addr1_q <= '0;
         mask1_q <= '0;
         data1_q <= '0;
         lo_q    <= '0;
      end else if (!bus.mem_stall) begin
         state_q <= state_d;
         if (w_accept) begin
            split_q <= w_split;
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            err_q   <= w_illegal;
            size_q  <= bus.req_size;
            off_q   <= w_off;
            addr1_q <= w_addr0 + ADDR_W'(NB);
            mask1_q <= w_mask2[2*NB-1:NB];
            data1_q <= w_data2[2*XLEN-1:XLEN];
         end
         if (state_q == S_SPLIT) begin
            lo_q <= bus.mem_dout;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.mem_addr = w_addr0;
      bus.mem_we   = '0;
      bus.mem_re   = 1'b0;
      bus.mem_din  = w_data2[XLEN-1:0];
      case (state_q)
         S_IDLE: begin
            if (w_accept) state_d = w_split ? S_SPLIT : S_WAIT;
         end
         S_SPLIT: begin
            state_d      = S_WAIT;
            bus.mem_addr = addr1_q;
            bus.mem_re   = ~we_q;
            bus.mem_we   = we_q ? mask1_q : '0;
            bus.mem_din  = data1_q;
         end
         S_WAIT: begin
            state_d = w_accept ? (w_split ? S_SPLIT : S_WAIT) : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (w_accept && !w_illegal) begin
         bus.mem_re = ~bus.req_we;
         bus.mem_we = bus.req_we ? w_mask2[NB-1:0] : '0;
      end
   end

   logic [2*XLEN-1:0]   w_pair;
   logic [XLEN-1:0]     w_low, w_keep, w_top, w_ext;
   logic [3:0]          w_bytes_q;
   logic                w_sign;

   always_comb begin
      w_bytes_q = 4'd1 << size_q;
      w_pair    = split_q ? {bus.mem_dout, lo_q} : {{XLEN{1'b0}}, bus.mem_dout};
      w_low     = XLEN'(w_pair >> {off_q, 3'b000});
      // w_top isolates the access's most significant bit for sign extension
      w_keep    = ~({XLEN{1'b1}} << {w_bytes_q, 3'b000});
      w_top     = w_keep ^ (w_keep >> 1);
      w_sign    = ~uns_q & (|(w_low & w_top));
      w_ext     = (w_low & w_keep) | ({XLEN{w_sign}} & ~w_keep);
   end

   assign bus.req_ready  = w_ready;
   assign bus.resp_valid = (state_q == S_WAIT);
   assign bus.resp_err   = (state_q == S_WAIT) && err_q;
   assign bus.resp_rdata = ((state_q == S_WAIT) && !we_q && !err_q) ? w_ext : '0;
endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// +----------------------------------------------------------------------+
// | tb_lsu_align : byte-level reference model, directed + random traffic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu_align;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   lsu_align_if #(.XLEN(32), .ADDR_W(32)) bus ();
   lsu_align #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- byte memory behind the cache port ----------------
   logic [7:0] mem [int unsigned];
   typedef struct { logic [31:0] a; logic [3:0] we; logic [31:0] d; logic re; int c; } beat_t;
   beat_t beat_q[$];
   bit          rd_pend = 0;
   logic [31:0] rd_addr;

   function automatic logic [7:0] mbyte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[7:4]};
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return {mbyte(a + 3), mbyte(a + 2), mbyte(a + 1), mbyte(a)};
   endfunction

   task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
   endtask

   always @(negedge clk) begin
      if (!reset && !bus.mem_stall && (bus.mem_re || (|bus.mem_we))) begin
         beat_q.push_back('{bus.mem_addr, bus.mem_we, bus.mem_din, bus.mem_re, cyc});
         if (bus.mem_re) begin
            rd_pend = 1;
            rd_addr = bus.mem_addr;
         end
         for (int i = 0; i < 4; i++)
            if (bus.mem_we[i]) mem[bus.mem_addr + i] = bus.mem_din[8*i +: 8];
      end
   end

   always @(posedge clk) begin
      #2;
      if (rd_pend) begin
         bus.mem_dout = rd_word(rd_addr);
         rd_pend = 0;
      end
   end

   int stall_cnt = 0;
   bit rnd_stall = 0;
   always @(posedge clk) begin
      #1;
      if (stall_cnt > 0) begin
         bus.mem_stall = 1'b1;
         stall_cnt--;
      end else begin
         bus.mem_stall = rnd_stall && ($urandom_range(0, 4) == 0);
      end
   end

   // ---------------- reference model: byte-by-byte placement ----------------
   typedef struct {
      bit split; bit err; bit we;
      logic [31:0] a0, a1;
      logic [3:0]  m0, m1;
      logic [31:0] d0, d1, rdata;
   } rec_t;

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic rec_t mk(input bit we, input logic [1:0] sz, input bit un,
                               input logic [31:0] ad, input logic [31:0] wd);
      rec_t r;
      int n;
      logic [31:0] ba, val;
      n = 1 << sz;
      r.we = we; r.err = (sz == 2'd3); r.split = 0;
      r.a0 = ad & ~32'd3; r.a1 = r.a0 + 32'd4;
      r.m0 = '0; r.m1 = '0; r.d0 = '0; r.d1 = '0; val = '0;
      if (!r.err) begin
         for (int k = 0; k < n; k++) begin
            ba = ad + k;
            if ((ba & ~32'd3) == r.a0) begin
               r.m0[ba[1:0]] = 1'b1;
               r.d0[8*ba[1:0] +: 8] = wd[8*k +: 8];
            end else begin
               r.split = 1;
               r.m1[ba[1:0]] = 1'b1;
               r.d1[8*ba[1:0] +: 8] = wd[8*k +: 8];
            end
            val[8*k +: 8] = mbyte(ba);
         end
         for (int j = n; j < 4; j++)
            val[8*j +: 8] = (!un && val[8*n-1]) ? 8'hFF : 8'h00;
      end
      r.rdata = (we || r.err) ? 32'd0 : val;
      return r;
   endfunction

   int   stage = 0;   // 0 free, 1 second-beat cycle, 2 response cycle
   rec_t cur, nr;
   bit   exp_ready, acc;

   always @(negedge clk) begin
      if (reset) begin
         stage = 0;
      end else begin
         exp_ready = (stage == 0) || (stage == 2 && !cur.split);
         chk("req_ready", bus.req_ready, exp_ready);
         chk("resp_valid", bus.resp_valid, stage == 2);
         if (stage == 2) begin
            chk("resp_err", bus.resp_err, cur.err);
            chk("resp_rdata", bus.resp_rdata, cur.rdata);
         end
         acc = bus.req_valid && exp_ready && !bus.mem_stall;
         if (stage == 1) begin
            chk("beat1_addr", bus.mem_addr, cur.a1);
            if (!bus.mem_stall) begin
               chk("beat1_re", bus.mem_re, !cur.we);
               chk("beat1_we", bus.mem_we, cur.we ? cur.m1 : 4'h0);
               if (cur.we) chk("beat1_din", bus.mem_din & lanes(cur.m1), cur.d1);
            end
         end else if (acc) begin
            nr = mk(bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata);
            if (nr.err) begin
               chk("illegal_strobes", {bus.mem_re, bus.mem_we}, 5'd0);
            end else begin
               chk("beat0_addr", bus.mem_addr, nr.a0);
               chk("beat0_re", bus.mem_re, !nr.we);
               chk("beat0_we", bus.mem_we, nr.we ? nr.m0 : 4'h0);
               if (nr.we) chk("beat0_din", bus.mem_din & lanes(nr.m0), nr.d0);
            end
         end else if (!bus.mem_stall) begin
            chk("idle_strobes", {bus.mem_re, bus.mem_we}, 5'd0);
         end
         if (!bus.mem_stall) begin
            if (acc) begin
               cur = nr;
               stage = nr.split ? 1 : 2;
            end else if (stage == 1) stage = 2;
            else stage = 0;
         end
      end
   end

   // ---------------- directed request driver ----------------
   logic [31:0] t_rdata;
   logic        t_err;
   int          t_lat, t_rlow, t_acc;

   task automatic do_req(input bit we, input logic [1:0] sz, input bit un,
                         input logic [31:0] ad, input logic [31:0] wd, input int stl);
      int n = 0;
      bit got = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
      bus.req_unsigned = un; bus.req_addr = ad; bus.req_wdata = wd;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.req_ready && !bus.mem_stall) got = 1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      t_acc = cyc;
      if (stl > 0) stall_cnt = stl;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      t_lat = 0; t_rlow = 0; got = 0;
      while (!got && t_lat < 20) begin
         @(negedge clk);
         t_lat++;
         if (!bus.req_ready) t_rlow++;
         if (bus.resp_valid && !bus.mem_stall) begin
            got = 1;
            t_rdata = bus.resp_rdata;
            t_err = bus.resp_err;
         end
      end
      if (!got) chk("resp_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   int n1;
   bit racc;
   int r;

   initial begin
      bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.mem_dout = 0; bus.mem_stall = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_mem_strobes", {bus.mem_re, bus.mem_we}, 0);
      reset = 0;
      #1 chk("rst_req_ready", bus.req_ready, 1);
      @(posedge clk); #1;

      // sw 0x11223344 @0x100
      beat_q.delete();
      do_req(1, 2'd2, 0, 32'h100, 32'h11223344, 0);
      chk("sw_nbeats", beat_q.size(), 1);
      if (beat_q.size() >= 1) begin
         chk("sw_addr", beat_q[0].a, 32'h100);
         chk("sw_we", beat_q[0].we, 4'b1111);
         chk("sw_din", beat_q[0].d, 32'h11223344);
         chk("sw_same_cycle", beat_q[0].c, t_acc);
      end
      chk("sw_lat", t_lat, 1);
      chk("sw_rdata", t_rdata, 0);

      // lh / lhu @0x102
      poke_word(32'h100, 32'hBEEF8001);
      do_req(0, 2'd1, 0, 32'h102, 0, 0);
      chk("lh_rdata", t_rdata, 32'hFFFFBEEF);
      chk("lh_lat", t_lat, 1);
      do_req(0, 2'd1, 1, 32'h102, 0, 0);
      chk("lhu_rdata", t_rdata, 32'h0000BEEF);

      // lw @0x103 crossing a word
      poke_word(32'h100, 32'hAABBCCDD);
      poke_word(32'h104, 32'h44332211);
      do_req(0, 2'd2, 0, 32'h103, 0, 0);
      chk("lw_split_rdata", t_rdata, 32'h332211AA);
      chk("lw_split_lat", t_lat, 2);
      chk("lw_split_rdy_low", t_rlow, 2);

      // sh wrapping the top of the address space
      beat_q.delete();
      do_req(1, 2'd1, 0, 32'hFFFFFFFF, 32'h0000A55A, 0);
      chk("sh_wrap_nbeats", beat_q.size(), 2);
      if (beat_q.size() >= 2) begin
         chk("sh_b0_addr", beat_q[0].a, 32'hFFFFFFFC);
         chk("sh_b0_we", beat_q[0].we, 4'b1000);
         chk("sh_b0_din", beat_q[0].d, 32'h5A000000);
         chk("sh_b1_addr", beat_q[1].a, 32'h00000000);
         chk("sh_b1_we", beat_q[1].we, 4'b0001);
         chk("sh_b1_din", beat_q[1].d, 32'h000000A5);
      end

      // split load stalled 3 cycles in SPLIT
      beat_q.delete();
      do_req(0, 2'd2, 0, 32'h103, 0, 3);
      n1 = 0;
      foreach (beat_q[i]) if (beat_q[i].a == 32'h104 && beat_q[i].re) n1++;
      chk("stall_beat1_reads", n1, 1);
      chk("stall_rdata", t_rdata, 32'h332211AA);
      chk("stall_lat", t_lat, 5);

      // illegal size on a 32-bit datapath
      beat_q.delete();
      do_req(0, 2'd3, 0, 32'h108, 0, 0);
      chk("illegal_err", t_err, 1);
      chk("illegal_rdata", t_rdata, 0);
      chk("illegal_nbeats", beat_q.size(), 0);

      // reset while in SPLIT
      bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'd2; bus.req_addr = 32'h106;
      @(negedge clk);
      @(posedge clk); #1;
      bus.req_valid = 0;
      #1 reset = 1;
      #1;
      chk("midrst_strobes", {bus.mem_re, bus.mem_we}, 0);
      chk("midrst_resp_valid", bus.resp_valid, 0);
      @(posedge clk); #1;
      reset = 0;
      #1;
      chk("postrst_ready", bus.req_ready, 1);
      chk("postrst_resp_valid", bus.resp_valid, 0);
      do_req(0, 2'd2, 0, 32'h100, 0, 0);
      chk("postrst_lw", t_rdata, 32'hAABBCCDD);
      chk("postrst_lat", t_lat, 1);

      // randomized back-to-back traffic with random stalls
      rnd_stall = 1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         racc = bus.req_valid && bus.req_ready && !bus.mem_stall;
         @(posedge clk); #1;
         if (racc || !bus.req_valid) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_we = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            bus.req_size = (r == 9) ? 2'd3 : 2'(r % 3);
            bus.req_unsigned = $urandom_range(0, 1);
            bus.req_addr = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                                       : 32'h200 + $urandom_range(0, 31);
            bus.req_wdata = $urandom;
         end
      end
      bus.req_valid = 0;
      repeat (8) @(posedge clk);
      rnd_stall = 0;
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
